// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, 1-cycle-latency data memory.
// Requester 1 can lock the memory for multi-word bursts; read data is steered back to its issuer.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NBYTES    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [NBYTES-1:0]     r0_we,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [NBYTES-1:0]     r1_we,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic                  r1_lock,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_en,
    output logic [NBYTES-1:0]     mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [31:0]           gnt_cnt0,
    output logic [31:0]           gnt_cnt1
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_prio;      // 0: r0 wins a tie, 1: r1 wins a tie
    logic                  r_rd0;
    logic                  r_rd1;
    logic [DATA_WIDTH-1:0] r_hold0;
    logic [DATA_WIDTH-1:0] r_hold1;
    logic [31:0]           r_gnt_cnt0;
    logic [31:0]           r_gnt_cnt1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_lock_hold;

    // State register, tie-break pointer, read-return tracking and grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_UNLOCKED;
            r_prio     <= 1'b0;
            r_rd0      <= 1'b0;
            r_rd1      <= 1'b0;
            r_hold0    <= '0;
            r_hold1    <= '0;
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0) begin
                r_prio <= 1'b1;
            end else if (w_gnt1) begin
                r_prio <= 1'b0;
            end
            r_rd0 <= w_gnt0 && (r0_we == '0);
            r_rd1 <= w_gnt1 && (r1_we == '0);
            if (r_rd0) begin
                r_hold0 <= mem_dout;
            end
            if (r_rd1) begin
                r_hold1 <= mem_dout;
            end
            r_gnt_cnt0 <= r_gnt_cnt0 + 32'(w_gnt0);
            r_gnt_cnt1 <= r_gnt_cnt1 + 32'(w_gnt1);
        end
    end

    // A dropped lock releases in the same cycle, so arbitration is already round-robin then.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_lock_hold = (r_state == ST_LOCKED) && r1_lock;

        if (w_lock_hold) begin
            w_gnt1 = r1_req;
        end else if (r0_req && r1_req) begin
            w_gnt0 = ~r_prio;
            w_gnt1 = r_prio;
        end else begin
            w_gnt0 = r0_req;
            w_gnt1 = r1_req;
        end

        case (r_state)
            ST_UNLOCKED: if (w_gnt1 && r1_lock) w_state_nxt = ST_LOCKED;
            ST_LOCKED:   if (!r1_lock)          w_state_nxt = ST_UNLOCKED;
            default:     w_state_nxt = ST_UNLOCKED;
        endcase
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign mem_en    = w_gnt0 | w_gnt1;
    assign mem_addr  = w_gnt1 ? r1_addr  : r0_addr;
    assign mem_din   = w_gnt1 ? r1_wdata : r0_wdata;
    assign mem_we    = w_gnt1 ? r1_we    : (w_gnt0 ? r0_we : '0);

    // Memory data is live only in the return cycle; otherwise replay the last word.
    assign r0_rvalid = r_rd0;
    assign r1_rvalid = r_rd1;
    assign r0_rdata  = r_rd0 ? mem_dout : r_hold0;
    assign r1_rdata  = r_rd1 ? mem_dout : r_hold1;
    assign gnt_cnt0  = r_gnt_cnt0;
    assign gnt_cnt1  = r_gnt_cnt1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: write-first BRAM model, reference memory and
// per-port read-data queues filled at grant time and drained on rvalid.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW / 8;

    logic          clk;
    logic          rst;
    logic          r0_req, r1_req, r1_lock;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [NB-1:0] r0_we, r1_we;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_en;
    logic [NB-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [31:0]   gnt_cnt0, gnt_cnt1;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] mem_tmp;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
        .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first block RAM with byte enables and one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_tmp = mem[mem_addr];
            for (int b = 0; b < int'(NB); b++)
                if (mem_we[b]) mem_tmp[b*8 +: 8] = mem_din[b*8 +: 8];
            mem[mem_addr] <= mem_tmp;
            mem_dout      <= mem_tmp;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every queued read must come back on the very next clock, and only then.
    always @(posedge clk) begin
        logic [DW-1:0] e;
        #2;
        if (r0_rvalid || q0.size() != 0) begin
            chk("r0_rvalid", 64'(r0_rvalid), 64'(q0.size() != 0));
            if (q0.size() != 0) begin
                e = q0.pop_front();
                if (r0_rvalid) chk("r0_rdata", 64'(r0_rdata), 64'(e));
            end
        end
        if (r1_rvalid || q1.size() != 0) begin
            chk("r1_rvalid", 64'(r1_rvalid), 64'(q1.size() != 0));
            if (q1.size() != 0) begin
                e = q1.pop_front();
                if (r1_rvalid) chk("r1_rdata", 64'(r1_rdata), 64'(e));
            end
        end
    end

    task automatic set_r0(input logic req, input logic [NB-1:0] we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
        r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = data;
    endtask

    task automatic set_r1(input logic req, input logic [NB-1:0] we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic lock);
        r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = data; r1_lock = lock;
    endtask

    task automatic model_grant(input int port, input logic [NB-1:0] we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (we == '0) begin
            if (!rst) begin
                if (port == 0) q0.push_back(ref_mem[addr[7:0]]);
                else           q1.push_back(ref_mem[addr[7:0]]);
            end
        end else begin
            for (int b = 0; b < int'(NB); b++)
                if (we[b]) ref_mem[addr[7:0]][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    // Inputs are set at a falling edge; check the combinational grant, then advance one clock.
    task automatic step(input logic eg0, input logic eg1, input string tag);
        #1;
        chk({tag, "_gnt0"}, 64'(r0_gnt), 64'(eg0));
        chk({tag, "_gnt1"}, 64'(r1_gnt), 64'(eg1));
        chk({tag, "_mem_en"}, 64'(mem_en), 64'(eg0 | eg1));
        if (!eg0 && !eg1) chk({tag, "_mem_we_idle"}, 64'(mem_we), 64'(0));
        if (eg0) model_grant(0, r0_we, r0_addr, r0_wdata);
        if (eg1) model_grant(1, r1_we, r1_addr, r1_wdata);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        mem[14'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
        mem[14'h05] = 32'h12345678; ref_mem[8'h05] = 32'h12345678;
        mem_dout = '0;
        rst = 1'b1;
        set_r0(1'b0, '0, '0, '0);
        set_r1(1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_cnt0", 64'(gnt_cnt0), 64'(0));
        chk("rst_cnt1", 64'(gnt_cnt1), 64'(0));
        chk("rst_rvalid", 64'({r0_rvalid, r1_rvalid}), 64'(0));
        rst = 1'b0;

        // Single r0 read of 0x10.
        set_r0(1'b1, '0, 14'h10, '0);
        step(1'b1, 1'b0, "rd0");
        chk("rd0_rvalid", 64'(r0_rvalid), 64'(1));
        chk("rd0_rdata", 64'(r0_rdata), 64'(32'hDEADBEEF));
        chk("rd0_r1_rvalid", 64'(r1_rvalid), 64'(0));
        chk("rd0_cnt0", 64'(gnt_cnt0), 64'(1));
        set_r0(1'b0, '0, '0, '0);
        step(1'b0, 1'b0, "idle0");

        // Both requesting continuously after reset: strict alternation from r0.
        rst = 1'b1;
        step(1'b0, 1'b0, "rst2");
        rst = 1'b0;
        set_r0(1'b1, '0, 14'h10, '0);
        set_r1(1'b1, '0, 14'h05, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, "rr_a");
            step(1'b0, 1'b1, "rr_b");
        end
        set_r0(1'b0, '0, '0, '0);
        set_r1(1'b0, '0, '0, '0, 1'b0);
        step(1'b0, 1'b0, "rr_idle");
        chk("rr_cnt0", 64'(gnt_cnt0), 64'(3));
        chk("rr_cnt1", 64'(gnt_cnt1), 64'(3));

        // Locked burst by r1 while r0 keeps requesting.
        set_r0(1'b1, '0, 14'h10, '0);
        step(1'b1, 1'b0, "pre_lock");
        set_r1(1'b1, 4'hF, 14'h0, 32'h11111111, 1'b1);
        step(1'b0, 1'b1, "lock_w0");
        set_r1(1'b1, 4'hF, 14'h1, 32'h22222222, 1'b1);
        step(1'b0, 1'b1, "lock_w1");
        set_r1(1'b1, 4'hF, 14'h2, 32'h33333333, 1'b1);
        step(1'b0, 1'b1, "lock_w2");
        set_r1(1'b1, 4'hF, 14'h3, 32'h44444444, 1'b0);
        step(1'b1, 1'b0, "unlock_r0");
        set_r0(1'b1, '0, 14'h1, '0);
        step(1'b0, 1'b1, "unlock_r1");
        set_r1(1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b0, "rd_burst");
        chk("rd_burst_data", 64'(r0_rdata), 64'(32'h22222222));

        // Lock asserted without a grant changes nothing.
        set_r1(1'b0, '0, '0, '0, 1'b1);
        set_r0(1'b1, '0, 14'h2, '0);
        step(1'b1, 1'b0, "nolock_a");
        step(1'b1, 1'b0, "nolock_b");
        set_r0(1'b0, '0, '0, '0);
        set_r1(1'b0, '0, '0, '0, 1'b0);

        // Partial byte write then read-after-write.
        set_r1(1'b1, 4'b0011, 14'h5, 32'hAAAABBBB, 1'b0);
        step(1'b0, 1'b1, "bw_wr");
        set_r1(1'b0, '0, '0, '0, 1'b0);
        set_r0(1'b1, '0, 14'h5, '0);
        step(1'b1, 1'b0, "bw_rd");
        chk("bw_rdata", 64'(r0_rdata), 64'(32'h1234BBBB));
        set_r0(1'b0, '0, '0, '0);
        step(1'b0, 1'b0, "bw_idle");
        chk("bw_hold", 64'(r0_rdata), 64'(32'h1234BBBB));

        // Enter LOCKED, then reset while an r0 read is being granted.
        set_r1(1'b1, 4'hF, 14'h6, 32'h66666666, 1'b1);
        step(1'b0, 1'b1, "lock_pre_rst");
        rst = 1'b1;
        set_r1(1'b0, '0, '0, '0, 1'b0);
        set_r0(1'b1, '0, 14'h10, '0);
        step(1'b1, 1'b0, "rst_rd");
        chk("rst_rd_cnt0", 64'(gnt_cnt0), 64'(0));
        chk("rst_rd_cnt1", 64'(gnt_cnt1), 64'(0));
        rst = 1'b0;
        set_r0(1'b0, '0, '0, '0);
        step(1'b0, 1'b0, "post_rst");
        chk("post_rst_rvalid", 64'(r0_rvalid), 64'(0));
        set_r1(1'b0, '0, '0, '0, 1'b1);
        set_r0(1'b1, '0, 14'h10, '0);
        step(1'b1, 1'b0, "post_rst_unlocked");
        set_r0(1'b0, '0, '0, '0);
        set_r1(1'b0, '0, '0, '0, 1'b0);

        // Counter wrap.
        force dut.r_gnt_cnt1 = 32'hFFFF_FFFF;
        #1;
        release dut.r_gnt_cnt1;
        set_r1(1'b1, 4'hF, 14'h7, 32'h77777777, 1'b0);
        step(1'b0, 1'b1, "wrap");
        chk("wrap_cnt1", 64'(gnt_cnt1), 64'(0));
        chk("wrap_cnt0", 64'(gnt_cnt0), 64'(1));
        set_r1(1'b0, '0, '0, '0, 1'b0);
        step(1'b0, 1'b0, "end_idle");
        chk("q_empty", 64'(q0.size() + q1.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
